// File: rtl/eviction_policy_pkg.sv
// Shared types and helpers for the per-set eviction policy engines.
package eviction_policy_pkg;

    // Widest way vector the helpers handle; callers zero-extend into this.
    localparam int unsigned MAX_WAYS = 64;

    typedef logic [MAX_WAYS-1:0] way_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        READY   = 2'd2
    } state_e;

    // Heap-style tree indexing: node i has children 2i+1 and 2i+2.
    function automatic int unsigned node_parent(input int unsigned node);
        return (node - 1) / 2;
    endfunction

    function automatic int unsigned node_left(input int unsigned node);
        return 2 * node + 1;
    endfunction

    function automatic int unsigned node_right(input int unsigned node);
        return 2 * node + 2;
    endfunction

    // Exactly one bit set.
    function automatic logic is_onehot(input way_vec_t v);
        return (v != '0) && ((v & (v - way_vec_t'(1))) == '0);
    endfunction

    // Index of the set bit; only meaningful for a one-hot input.
    function automatic int unsigned onehot_to_idx(input way_vec_t v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_WAYS; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    function automatic way_vec_t idx_to_onehot(input int unsigned idx);
        return way_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU bits for one set: path updates on access, combinational victim walk.
module plru_tree
    import eviction_policy_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit_i,
    input  logic [IDX_W-1:0] hit_idx_i,
    input  logic             alloc_i,
    input  logic [IDX_W-1:0] alloc_idx_i,
    output logic [IDX_W-1:0] victim_idx_c_o
);

    localparam int unsigned TREE_W = NUM_WAYS - 1;
    localparam int unsigned LEVELS = IDX_W;

    logic [TREE_W-1:0] tree_q;
    logic [TREE_W-1:0] tree_d;

    // Point every node on the path to 'way' at the opposite subtree.
    function automatic logic [TREE_W-1:0] touch(input logic [TREE_W-1:0] bits,
                                                 input logic [IDX_W-1:0]  way);
        logic [TREE_W-1:0] r;
        logic [TREE_W-1:0] m;
        int unsigned       node;
        int unsigned       par;
        r    = bits;
        node = TREE_W + 32'(way);
        for (int unsigned l = 0; l < LEVELS; l++) begin
            par = node_parent(node);
            m   = TREE_W'(1) << par;
            // Odd heap index is a left child, so the victim side becomes right.
            if (node[0]) begin
                r = r | m;
            end else begin
                r = r & ~m;
            end
            node = par;
        end
        return r;
    endfunction

    // Follow the bits from the root: 0 goes left, 1 goes right.
    function automatic logic [IDX_W-1:0] walk(input logic [TREE_W-1:0] bits);
        logic [TREE_W-1:0] sel;
        int unsigned       node;
        node = 0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            sel  = bits >> node;
            node = sel[0] ? node_right(node) : node_left(node);
        end
        return IDX_W'(node - TREE_W);
    endfunction

    // Hit is applied first so allocate wins on any shared node.
    always_comb begin
        tree_d = tree_q;
        if (hit_i) begin
            tree_d = touch(tree_d, hit_idx_i);
        end
        if (alloc_i) begin
            tree_d = touch(tree_d, alloc_idx_i);
        end
    end

    // Tree bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

    assign victim_idx_c_o = walk(tree_q);

endmodule

// File: rtl/plru_eviction_policy.sv
// Per-set PLRU eviction engine: validity tracking, invalid-first victim choice, request FSM.
module plru_eviction_policy
    import eviction_policy_pkg::*;
#(
    parameter int unsigned NUM_WAYS      = 8,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_WAYS-1:0] hitWay,
    input  logic                hit,
    input  logic [NUM_WAYS-1:0] missWay,
    input  logic                miss,
    input  logic [NUM_WAYS-1:0] allocateWay,
    input  logic                allocate,
    output logic [NUM_WAYS-1:0] evictionTarget,
    output logic                evictionReady,
    output logic                protocolError
);

    localparam int unsigned IDX_W = $clog2(NUM_WAYS);

    logic                hit_ok_c;
    logic                alloc_ok_c;
    logic                hit_bad_c;
    logic                alloc_bad_c;
    logic [IDX_W-1:0]    hit_idx_c;
    logic [IDX_W-1:0]    alloc_idx_c;
    logic [IDX_W-1:0]    victim_idx_c;
    logic [NUM_WAYS-1:0] free_c;
    logic [NUM_WAYS-1:0] pick_c;

    state_e              state_q;
    state_e              state_d;
    logic [NUM_WAYS-1:0] valid_q;
    logic [NUM_WAYS-1:0] valid_d;
    logic [NUM_WAYS-1:0] target_q;
    logic [NUM_WAYS-1:0] target_d;
    logic                ready_q;
    logic                ready_d;
    logic                perr_q;
    logic                perr_d;

    // The miss way vector and address width are part of the shared interface only.
    logic unused_c;
    assign unused_c = ^{missWay, ADDRESS_WIDTH[0]};

    // Strobe qualification: malformed way vectors are dropped and flagged.
    always_comb begin
        hit_ok_c    = hit      &&  is_onehot(MAX_WAYS'(hitWay));
        hit_bad_c   = hit      && !is_onehot(MAX_WAYS'(hitWay));
        alloc_ok_c  = allocate &&  is_onehot(MAX_WAYS'(allocateWay));
        alloc_bad_c = allocate && !is_onehot(MAX_WAYS'(allocateWay));
        hit_idx_c   = IDX_W'(onehot_to_idx(MAX_WAYS'(hitWay)));
        alloc_idx_c = IDX_W'(onehot_to_idx(MAX_WAYS'(allocateWay)));
    end

    plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_tree (
        .clk            (clk),
        .reset          (reset),
        .hit_i          (hit_ok_c),
        .hit_idx_i      (hit_idx_c),
        .alloc_i        (alloc_ok_c),
        .alloc_idx_i    (alloc_idx_c),
        .victim_idx_c_o (victim_idx_c)
    );

    // Victim choice: lowest-index invalid way, otherwise the tree victim.
    always_comb begin
        free_c = ~valid_q;
        if (|free_c) begin
            pick_c = free_c & (~free_c + NUM_WAYS'(1));
        end else begin
            pick_c = NUM_WAYS'(idx_to_onehot(32'(victim_idx_c)));
        end
    end

    // Next-state logic for the request FSM, valid bits and output registers.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        perr_d   = hit_bad_c | alloc_bad_c;

        if (alloc_ok_c) begin
            valid_d = valid_q | allocateWay;
        end

        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                state_d  = READY;
                target_d = pick_c;
                ready_d  = 1'b1;
            end
            READY: begin
                if (alloc_ok_c) begin
                    state_d  = IDLE;
                    target_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                target_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            target_q <= '0;
            ready_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            target_q <= target_d;
            ready_q  <= ready_d;
            perr_q   <= perr_d;
        end
    end

    assign evictionTarget = target_q;
    assign evictionReady  = ready_q;
    assign protocolError  = perr_q;

endmodule

// File: tb/tb_plru_eviction_policy.sv
// Bench for plru_eviction_policy: directed scenarios plus random traffic against a range-based PLRU model.
module tb_plru_eviction_policy;

    localparam int unsigned NW = 4;
    localparam int unsigned LV = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NW-1:0] hitWay;
    logic          hit;
    logic [NW-1:0] missWay;
    logic          miss;
    logic [NW-1:0] allocateWay;
    logic          allocate;
    logic [NW-1:0] evictionTarget;
    logic          evictionReady;
    logic          protocolError;

    always #5 clk = ~clk;

    plru_eviction_policy #(
        .NUM_WAYS      (NW),
        .ADDRESS_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hitWay         (hitWay),
        .hit            (hit),
        .missWay        (missWay),
        .miss           (miss),
        .allocateWay    (allocateWay),
        .allocate       (allocate),
        .evictionTarget (evictionTarget),
        .evictionReady  (evictionReady),
        .protocolError  (protocolError)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: for each aligned way range at each level, which half is least recently used (0 left, 1 right).
    int            lru_half [LV][NW];
    bit            vld [NW];
    int            ph;          // 0 idle, 1 selecting, 2 answer held
    logic [NW-1:0] m_tgt;
    bit            m_rdy;
    bit            m_err;

    function automatic bit legal(input logic [NW-1:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int idx_of(input logic [NW-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < NW; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic m_touch(input int w);
        for (int lvl = 0; lvl < LV; lvl++) begin
            int grp;
            int half;
            grp  = w >> (LV - lvl);
            half = (w >> (LV - 1 - lvl)) & 1;
            lru_half[lvl][grp] = 1 - half;
        end
    endtask

    function automatic logic [NW-1:0] m_choose();
        logic [NW-1:0] one;
        int            w;
        one = 1;
        for (int i = 0; i < NW; i++) if (!vld[i]) return one << i;
        w = 0;
        for (int lvl = 0; lvl < LV; lvl++) w = w * 2 + lru_half[lvl][w];
        return one << w;
    endfunction

    task automatic m_clear();
        for (int l = 0; l < LV; l++) for (int g = 0; g < NW; g++) lru_half[l][g] = 0;
        for (int i = 0; i < NW; i++) vld[i] = 1'b0;
        ph    = 0;
        m_tgt = '0;
        m_rdy = 1'b0;
        m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic m_edge();
        bit hok;
        bit aok;
        if (reset) begin
            m_clear();
            return;
        end
        hok   = hit && legal(hitWay);
        aok   = allocate && legal(allocateWay);
        m_err = (hit && !legal(hitWay)) || (allocate && !legal(allocateWay));
        case (ph)
            0: if (miss) ph = 1;
            1: begin
                m_tgt = m_choose();
                m_rdy = 1'b1;
                ph    = 2;
            end
            default: if (aok) begin
                ph    = 0;
                m_tgt = '0;
                m_rdy = 1'b0;
            end
        endcase
        if (hok) m_touch(idx_of(hitWay));
        if (aok) begin
            m_touch(idx_of(allocateWay));
            vld[idx_of(allocateWay)] = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic h, input logic [NW-1:0] hw,
                        input logic m, input logic a, input logic [NW-1:0] aw);
        reset       = r;
        hit         = h;
        hitWay      = hw;
        miss        = m;
        missWay     = NW'($urandom);
        allocate    = a;
        allocateWay = aw;
        @(posedge clk);
        m_edge();
        #1;
        check("ready",  32'(evictionReady),  32'(m_rdy));
        check("target", 32'(evictionTarget), 32'(m_tgt));
        check("perr",   32'(protocolError),  32'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] one;
        one = 1;
        if ($urandom_range(99) < 85) return one << $urandom_range(NW - 1);
        return NW'($urandom);
    endfunction

    initial begin
        m_clear();
        reset = 1'b1; hit = 1'b0; hitWay = '0; miss = 1'b0; missWay = '0;
        allocate = 1'b0; allocateWay = '0;

        // Reset values.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        check("rst_ready", 32'(evictionReady), 32'd0);

        // Cold miss: ready two cycles after the miss, way 0.
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        check("cold_not_yet", 32'(evictionReady), 32'd0);
        idle();
        check("cold_ready", 32'(evictionReady), 32'd1);
        check("cold_tgt", 32'(evictionTarget), 32'b0001);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b0001);
        check("cold_end", 32'(evictionReady), 32'd0);

        // Fill all ways in order: tree victim is way 0.
        for (int w = 0; w < NW; w++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'(1 << w));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle();
        check("full_tgt", 32'(evictionTarget), 32'b0001);
        // Ending with way 0 touches the same path a hit on way 0 would.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle();
        check("hit0_tgt", 32'(evictionTarget), 32'b0100);

        // Hit on the held target does not move it; allocate of another way ends the request.
        step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, '0);
        check("held_tgt", 32'(evictionTarget), 32'b0100);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b1000);
        check("end_other", 32'(evictionReady), 32'd0);

        // Multi-hot hit: error pulse only, no tree change; bad allocate in READY keeps request.
        step(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, '0);
        check("perr_pulse", 32'(protocolError), 32'd1);
        idle();
        check("perr_clear", 32'(protocolError), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b0000);
        check("bad_alloc_keeps", 32'(evictionReady), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b0110);
        check("multi_alloc_keeps", 32'(evictionReady), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, m_tgt);

        // Reset during selection aborts and clears validity.
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        idle();
        check("abort_ready", 32'(evictionReady), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle();
        check("post_rst_tgt", 32'(evictionTarget), 32'b0001);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4'b0001);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            logic          r;
            logic          h;
            logic          m;
            logic          a;
            logic [NW-1:0] hw;
            logic [NW-1:0] aw;
            r  = ($urandom_range(199) == 0);
            h  = ($urandom_range(2) == 0);
            hw = rand_vec();
            m  = ($urandom_range(2) == 0);
            a  = ($urandom_range(3) == 0);
            aw = rand_vec();
            if (ph == 2 && $urandom_range(1) == 0) begin
                a  = 1'b1;
                aw = m_tgt;
            end
            step(r, h, hw, m, a, aw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
